// File: rtl/auto_player_pkg.sv
// Shared types for the automatic song sequencer: FSM states, ROM entry layout
// and the song table used to build the song ROM.
package auto_player_pkg;

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, PLAY, GAP} state_t;

  localparam int OCT_W    = 3;
  localparam int NOTE_W   = 3;
  localparam int LEN_W    = 4;
  localparam int ENTRY_W  = OCT_W + NOTE_W + LEN_W;
  localparam int LEN_LSB  = 0;
  localparam int NOTE_LSB = LEN_LSB + LEN_W;
  localparam int OCT_LSB  = NOTE_LSB + NOTE_W;

  localparam logic [LEN_W-1:0]  END_LEN   = 4'd0;
  localparam logic [NOTE_W-1:0] NOTE_REST = 3'd0;

  typedef struct packed {
    logic [OCT_W-1:0]  octave;
    logic [NOTE_W-1:0] note;
    logic [LEN_W-1:0]  length;
  } entry_t;

  function automatic entry_t make_entry(logic [OCT_W-1:0] o, logic [NOTE_W-1:0] n,
                                        logic [LEN_W-1:0] l);
    logic [ENTRY_W-1:0] raw;
    raw = '0;
    raw[OCT_LSB  +: OCT_W]  = o;
    raw[NOTE_LSB +: NOTE_W] = n;
    raw[LEN_LSB  +: LEN_W]  = l;
    return entry_t'(raw);
  endfunction

  // Song 2 has no end marker on purpose: it runs to the last ROM slot.
  function automatic entry_t song_data(int unsigned song_sel, int unsigned idx);
    entry_t e;
    e = make_entry(3'd0, NOTE_REST, END_LEN);
    case (song_sel)
      0: case (idx)
           0: e = make_entry(3'd4, 3'd1, 4'd2);
           1: e = make_entry(3'd4, 3'd3, 4'd1);
           default: ;
         endcase
      1: case (idx)
           0: e = make_entry(3'd5, NOTE_REST, 4'd3);
           1: e = make_entry(3'd5, 3'd5, 4'd1);
           default: ;
         endcase
      2: e = make_entry(3'd3, 3'((idx % 7) + 1), 4'd1);
      3: if (idx < 7) e = make_entry(3'd4, 3'(idx + 1), 4'd2);
      default: ;
    endcase
    return e;
  endfunction

  function automatic logic [6:0] note_led(logic [NOTE_W-1:0] n);
    logic [6:0] l;
    l = '0;
    if (n != NOTE_REST) l[n - 3'd1] = 1'b1;
    return l;
  endfunction

endpackage

// File: rtl/auto_player_if.sv
// Control and tone-generator signals between mode-select logic (master)
// and the song sequencer (slave).
interface auto_player_if #(
  parameter int SONG_W = 3,
  parameter int IDX_W  = 6
);
  logic              en;
  logic              start;
  logic              stop;
  logic              loop;
  logic [SONG_W-1:0] song;
  logic [2:0]        octave;
  logic [2:0]        note;
  logic              tone_valid;
  logic [6:0]        led;
  logic              busy;
  logic              done;
  logic [IDX_W-1:0]  note_idx;

  modport master (
    output en, start, stop, loop, song,
    input  octave, note, tone_valid, led, busy, done, note_idx
  );

  modport slave (
    input  en, start, stop, loop, song,
    output octave, note, tone_valid, led, busy, done, note_idx
  );
endinterface

// File: rtl/song_rom.sv
// Song ROM addressed by {song, idx}; one-cycle registered read.
module song_rom
  import auto_player_pkg::*;
#(
  parameter int SONG_W = 3,
  parameter int IDX_W  = 6
) (
  input  logic                    clk,
  input  logic [SONG_W+IDX_W-1:0] addr,
  output entry_t                  data
);

  // NOTE: the read register carries no reset; it only matters in LOAD,
  // which is always preceded by a FETCH that loads it.
  always_ff @(posedge clk) begin
    data <= song_data(32'(addr[SONG_W+IDX_W-1:IDX_W]), 32'(addr[IDX_W-1:0]));
  end

endmodule

// File: rtl/auto_player.sv
// Automatic song sequencer: walks ROM entries of the selected song and drives
// octave/note/tone_valid to the tone generator, with pause, stop and loop.
module auto_player
  import auto_player_pkg::*;
#(
  parameter int unsigned NUM_SONGS = 8,
  parameter int unsigned MAX_NOTES = 64,
  parameter int unsigned UNIT_CYC  = 6_250_000,
  parameter int unsigned GAP_CYC   = 500_000
) (
  input  logic          clk,
  input  logic          rst_n,
  auto_player_if.slave  bus
);

  localparam int SONG_W = $clog2(NUM_SONGS);
  localparam int IDX_W  = $clog2(MAX_NOTES);
  localparam int CNT_W  = $clog2(15 * UNIT_CYC + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_NOTES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t            state;
  logic [SONG_W-1:0] song_q;
  logic [IDX_W-1:0]  idx;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        octave_q, note_q;
  logic [6:0]        led_q;
  logic              tone_q, busy_q, done_q;
  entry_t            entry;
  logic              song_end;

  song_rom #(.SONG_W(SONG_W), .IDX_W(IDX_W)) u_rom (
    .clk  (clk),
    .addr ({song_q, idx}),
    .data (entry)
  );

  // Both end-of-song routes (marker in LOAD, last slot after GAP) share one path.
  assign song_end = (state == LOAD && entry.length == END_LEN) ||
                    (state == GAP && cnt <= CNT_ONE && idx == LAST_IDX);

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n || bus.stop) begin
      state    <= IDLE;
      song_q   <= '0;
      idx      <= '0;
      cnt      <= '0;
      octave_q <= '0;
      note_q   <= '0;
      led_q    <= '0;
      tone_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.en) begin
        if (song_end) begin
          idx <= '0;
          if (bus.loop) begin
            state <= FETCH;
          end else begin
            state    <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            octave_q <= '0;
            note_q   <= '0;
          end
        end else begin
          unique case (state)
            IDLE: if (bus.start) begin
              song_q <= bus.song;
              idx    <= '0;
              busy_q <= 1'b1;
              state  <= FETCH;
            end
            FETCH: state <= LOAD;
            LOAD: begin
              octave_q <= entry.octave;
              note_q   <= entry.note;
              tone_q   <= (entry.note != NOTE_REST);
              led_q    <= note_led(entry.note);
              cnt      <= CNT_W'(entry.length) * CNT_W'(UNIT_CYC);
              state    <= PLAY;
            end
            PLAY: if (cnt <= CNT_ONE) begin
              tone_q <= 1'b0;
              led_q  <= '0;
              cnt    <= CNT_W'(GAP_CYC);
              state  <= GAP;
            end else begin
              cnt <= cnt - CNT_ONE;
            end
            GAP: if (cnt <= CNT_ONE) begin
              idx   <= idx + IDX_W'(1);
              state <= FETCH;
            end else begin
              cnt <= cnt - CNT_ONE;
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

  // Pause must silence in the same cycle en drops, so the sound enables are gated by en.
  assign bus.tone_valid = tone_q & bus.en;
  assign bus.led        = led_q & {7{bus.en}};
  assign bus.octave     = octave_q;
  assign bus.note       = note_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.note_idx   = idx;

endmodule

// File: tb/tb_auto_player.sv
// Directed bench for auto_player: per-cycle expected output vectors are queued
// from the timing plan and compared against the DUT at each negedge.
module tb_auto_player;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       tv;
    logic [2:0] oct;
    logic [2:0] note;
    logic [6:0] led;
    logic [1:0] idx;
  } vec_t;

  logic clk;
  logic rst_n;
  auto_player_if #(.SONG_W(3), .IDX_W(2)) bus ();

  auto_player #(.NUM_SONGS(8), .MAX_NOTES(4), .UNIT_CYC(4), .GAP_CYC(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  vec_t       exp_q[$];
  int         n_vec  = 0;
  int         n_miss = 0;
  int         cyc    = 0;
  string      tag    = "reset";
  logic [2:0] h_oct  = '0;
  logic [2:0] h_note = '0;

  function automatic logic [6:0] onehot(logic [2:0] n);
    logic [6:0] one;
    one = 7'd1;
    return (n == 3'd0) ? 7'd0 : (one << (n - 3'd1));
  endfunction

  task automatic push(logic b, logic d, logic t, logic [2:0] o, logic [2:0] n,
                      logic [6:0] l, logic [1:0] i);
    vec_t v;
    v = '{busy: b, done: d, tv: t, oct: o, note: n, led: l, idx: i};
    exp_q.push_back(v);
  endtask

  task automatic push_idle(int n);
    h_oct  = '0;
    h_note = '0;
    repeat (n) push(0, 0, 0, 3'd0, 3'd0, 7'd0, 2'd0);
  endtask

  task automatic push_fetch_load(logic [1:0] i);
    repeat (2) push(1, 0, 0, h_oct, h_note, 7'd0, i);
  endtask

  task automatic push_play(logic [2:0] o, logic [2:0] n, int cycles, logic [1:0] i);
    h_oct  = o;
    h_note = n;
    repeat (cycles) push(1, 0, (n != 3'd0), o, n, onehot(n), i);
  endtask

  task automatic push_paused(int cycles, logic [1:0] i);
    repeat (cycles) push(1, 0, 0, h_oct, h_note, 7'd0, i);
  endtask

  task automatic push_gap(logic [1:0] i);
    repeat (2) push(1, 0, 0, h_oct, h_note, 7'd0, i);
  endtask

  task automatic push_entry(logic [1:0] i, logic [2:0] o, logic [2:0] n, int len);
    push_fetch_load(i);
    push_play(o, n, len * 4, i);
    push_gap(i);
  endtask

  task automatic push_done();
    h_oct  = '0;
    h_note = '0;
    push(0, 1, 0, 3'd0, 3'd0, 7'd0, 2'd0);
  endtask

  // One clock cycle: compare at negedge, then move to just after the next posedge.
  task automatic tick();
    vec_t act, exp;
    @(negedge clk);
    act = {bus.busy, bus.done, bus.tone_valid, bus.octave, bus.note, bus.led, bus.note_idx};
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    n_vec++;
    assert (act === exp) else begin
      n_miss++;
      $error("FAIL %s cycle %0d: observed busy/done/tv/oct/note/led/idx=%b/%b/%b/%0d/%0d/%b/%0d expected %b/%b/%b/%0d/%0d/%b/%0d",
             tag, cyc, act.busy, act.done, act.tv, act.oct, act.note, act.led, act.idx,
             exp.busy, exp.done, exp.tv, exp.oct, exp.note, exp.led, exp.idx);
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    cyc++;
  endtask

  task automatic run(int n);
    repeat (n) tick();
  endtask

  task automatic check_drained();
    n_vec++;
    assert (exp_q.size() == 0) else begin
      n_miss++;
      $error("FAIL %s drained: observed %0d leftover vectors expected 0", tag, exp_q.size());
    end
  endtask

  task automatic begin_scenario(string name);
    tag = name;
    cyc = 0;
    exp_q.delete();
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.en    = 1'b1;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.loop  = 1'b0;
    bus.song  = 3'd0;
    @(posedge clk);
    #1;

    begin_scenario("reset");
    push_idle(3);
    run(2);
    rst_n = 1'b1;
    run(1);
    check_drained();

    begin_scenario("basic");
    bus.song  = 3'd0;
    bus.start = 1'b1;
    push_idle(1);
    push_entry(2'd0, 3'd4, 3'd1, 2);
    push_entry(2'd1, 3'd4, 3'd3, 1);
    push_fetch_load(2'd2);
    push_done();
    push_idle(2);
    run(exp_q.size());
    check_drained();

    begin_scenario("loop");
    bus.loop  = 1'b1;
    bus.start = 1'b1;
    push_idle(1);
    push_entry(2'd0, 3'd4, 3'd1, 2);
    push_entry(2'd1, 3'd4, 3'd3, 1);
    push_fetch_load(2'd2);
    push_fetch_load(2'd0);
    push_play(3'd4, 3'd1, 4, 2'd0);
    run(exp_q.size() - 1);
    bus.stop = 1'b1;
    run(1);
    bus.stop = 1'b0;
    bus.loop = 1'b0;
    push_idle(2);
    run(2);
    check_drained();

    begin_scenario("pause");
    bus.start = 1'b1;
    push_idle(1);
    push_fetch_load(2'd0);
    push_play(3'd4, 3'd1, 2, 2'd0);
    push_paused(10, 2'd0);
    push_play(3'd4, 3'd1, 6, 2'd0);
    push_gap(2'd0);
    push_entry(2'd1, 3'd4, 3'd3, 1);
    push_fetch_load(2'd2);
    push_done();
    push_idle(1);
    run(5);
    bus.en = 1'b0;
    run(10);
    bus.en = 1'b1;
    run(exp_q.size());
    check_drained();

    begin_scenario("start_while_paused");
    push_idle(2);
    bus.en    = 1'b0;
    bus.start = 1'b1;
    run(1);
    bus.en = 1'b1;
    run(1);
    check_drained();

    begin_scenario("stop");
    bus.start = 1'b1;
    push_idle(1);
    push_fetch_load(2'd0);
    push_play(3'd4, 3'd1, 3, 2'd0);
    push_paused(1, 2'd0);
    run(6);
    bus.stop = 1'b1;
    bus.en   = 1'b0;
    run(1);
    bus.stop = 1'b0;
    bus.en   = 1'b1;
    push_idle(2);
    run(1);
    bus.start = 1'b1;
    run(1);
    push_fetch_load(2'd0);
    push_entry_tail: begin
      push_play(3'd4, 3'd1, 8, 2'd0);
      push_gap(2'd0);
    end
    push_entry(2'd1, 3'd4, 3'd3, 1);
    push_fetch_load(2'd2);
    push_done();
    push_idle(1);
    run(exp_q.size());
    check_drained();

    begin_scenario("stop_beats_start");
    push_idle(2);
    bus.stop  = 1'b1;
    bus.start = 1'b1;
    run(1);
    bus.stop = 1'b0;
    run(1);
    check_drained();

    begin_scenario("rest");
    bus.song  = 3'd1;
    bus.start = 1'b1;
    push_idle(1);
    push_entry(2'd0, 3'd5, 3'd0, 3);
    push_entry(2'd1, 3'd5, 3'd5, 1);
    push_fetch_load(2'd2);
    push_done();
    push_idle(1);
    run(20);
    bus.song  = 3'd0;
    bus.start = 1'b1;
    run(exp_q.size());
    check_drained();

    begin_scenario("reset_mid_play");
    bus.song  = 3'd0;
    bus.start = 1'b1;
    push_idle(1);
    push_fetch_load(2'd0);
    push_play(3'd4, 3'd1, 3, 2'd0);
    push_idle(2);
    run(5);
    rst_n = 1'b0;
    run(1);
    rst_n = 1'b1;
    run(2);
    check_drained();

    begin_scenario("wrap");
    bus.song  = 3'd2;
    bus.start = 1'b1;
    push_idle(1);
    for (int i = 0; i < 4; i++) push_entry(2'(i), 3'd3, 3'(i + 1), 1);
    push_done();
    push_idle(1);
    run(10);
    bus.song = 3'd0;
    run(exp_q.size());
    check_drained();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/auto_player.md
# auto_player

Parametrised automatic song sequencer, the successor to the fixed single-note auto mode. It steps through note entries stored in a per-song ROM and drives the tone generator (`Sound`) with octave, note and tone_valid. Note duration, inter-note gap and song count are configurable, and it adds loop, pause (via `en`) and stop. It sits between the mode-select logic and `Sound`, and drives the note LEDs.

## Interface
- `NUM_SONGS`, 8: number of songs in ROM; `SONG_W = $clog2(NUM_SONGS)`
- `MAX_NOTES`, 64: entries per song; `IDX_W = $clog2(MAX_NOTES)`
- `UNIT_CYC`, 6_250_000: clk cycles per length unit (1/16 s at 100 MHz)
- `GAP_CYC`, 500_000: silent cycles after every entry (articulation)

Ports (direction, width, meaning):
- `clk` in 1: system clock; one clock domain.
- `rst_n` in 1: reset, synchronous, active-low.
- `en` in 1: 1 = run; 0 = pause (freeze everything, silence).
- `start` in 1: one-cycle pulse; begins playback of `song`.
- `stop` in 1: abort playback, return to IDLE.
- `loop` in 1: at end-of-song, restart from entry 0.
- `song` in SONG_W: song select, latched on accepted `start`.
- `octave` out 3: octave to `Sound`.
- `note` out 3: 0 = rest, 1..7 = do..si.
- `tone_valid` out 1: `Sound` may sound `octave`/`note`.
- `led` out 7: one-hot of current note (`led[note-1]`).
- `busy` out 1: not IDLE.
- `done` out 1: one-cycle pulse on natural song end.
- `note_idx` out IDX_W: index of current entry.

## Operation
- ROM entry, 10 bits: `{octave[2:0], note[2:0], length[3:0]}`. `length` 1..15 = duration in units. `length == 0` = end marker.
- States and transitions:
  - IDLE: on `start`, latch `song`, set idx = 0, go to FETCH.
  - FETCH: present address; 1 cycle.
  - LOAD: ROM data valid; 1 cycle.
    - End marker: if `loop`, idx = 0 and go to FETCH. Otherwise pulse `done` and go to IDLE.
    - Otherwise latch the entry, load the counter with length·UNIT_CYC, go to PLAY.
  - PLAY: `tone_valid = (note != 0)` for length·UNIT_CYC cycles, then go to GAP.
  - GAP: `tone_valid = 0` for GAP_CYC cycles. If idx == MAX_NOTES−1, take the end-of-song path (loop or done). Otherwise idx++ and go to FETCH.
- `led`: one-hot of `note` while in PLAY with note ≠ 0; otherwise 0.
- `octave`/`note` hold the last entry values through GAP. They are cleared to 0 in IDLE.
- `en = 0`: state, counters and idx are frozen, and `tone_valid`/`led` are forced to 0. On `en = 1`, the remaining duration resumes. `start` is ignored while `en = 0`.
- `start` while busy: ignored (no restart).
- `stop` has priority over everything, including `start` and `en = 0`. Next cycle: IDLE, all outputs 0, no `done`.
- `song` changes outside an accepted `start` have no effect.
- Duration counter width: `$clog2(15·UNIT_CYC + 1)`. No overflow permitted at defaults.

## Timing
- All outputs registered. Reset value of every output is 0; state is IDLE.
- `start` sampled at cycle 0 → `busy = 1` at cycle 1 (FETCH) → LOAD at cycle 2 → `tone_valid`/`led`/`note` valid from cycle 3.
- Per entry period: 2 + length·UNIT_CYC + GAP_CYC cycles.
- End marker seen in LOAD at cycle t → `done = 1` and `busy = 0` at cycle t+1, for exactly one cycle.
- Loop restart: end marker in LOAD at cycle t → FETCH of entry 0 at t+1. No `done` pulse.
- Reset asserted mid-note takes effect at the next edge: outputs 0, state IDLE.

## Structure
- Package `auto_player_pkg`:
  - state enum (IDLE, FETCH, LOAD, PLAY, GAP)
  - entry field widths and offsets
  - `END_LEN = 4'd0`
  - `NOTE_REST = 3'd0`
  - entry type
- Sub-module `song_rom`: NUM_SONGS × MAX_NOTES × 10 bits, address `{song, idx}`, 1-cycle registered read.
- Top holds the FSM, duration counter, idx and output registers.

## Test plan
All scenarios use UNIT_CYC = 4 and GAP_CYC = 2. Song 0 = {(4,1,2), (4,3,1), END}.
- **Basic play:** `start` on song 0 at cycle 0.
  - Cycles 3–10: `tone_valid = 1`, octave 4, note 1, `led = 7'b0000001`.
  - Cycles 11–12: silent.
  - Cycles 15–18: note 3, `led = 7'b0000100`.
  - Cycle 23: `done = 1`, `busy = 0`.
- **Loop:** `loop = 1` on song 0. Entry 0 FETCH at cycle 23, note 1 again from cycle 25; `done` is never asserted.
- **Pause:** `en = 0` during cycles 5–14. `tone_valid = 0` throughout; note 1 resumes at cycle 15 and ends at cycle 20 (8 sounding cycles total).
- **Stop:** `stop` at cycle 6. Cycle 7: all outputs 0, IDLE, no `done`. A `start` at cycle 8 replays from entry 0.
- **Rest and ignored start:** song with entry (5,0,3). `tone_valid = 0` and `led = 0` for 12 cycles while `busy = 1`. A second `start` mid-song does not reset `note_idx`.
- **Reset and no-end-marker wrap:** `rst_n = 0` mid-PLAY gives all outputs 0 next cycle. With MAX_NOTES = 4 and no end marker, `done` pulses after the GAP of entry 3.
